// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame levels, FSM state encodings and parity helper
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    function automatic logic parity_even(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop serial line synchronizer with falling-edge detect
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic serial_i,
    output logic rxs_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= IDLE_LEVEL;
            s2_q   <= IDLE_LEVEL;
            prev_q <= IDLE_LEVEL;
        end else begin
            s1_q   <= serial_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rxs_o  = s2_q;
    assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver; define UART_RX_PARITY_EN to expect an even-parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic rxs;
    logic fall;

    uart_rx_sync u_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .serial_i (serial_in),
        .rxs_o    (rxs),
        .fall_o   (fall)
    );

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        stop_d       = stop_q;
        done_d       = done_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rxs == START_LEVEL) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    perr_d  = rxs ^ parity_even(shift_q);
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Results are published one cycle after the stop sample, together with leaving STOP.
                if (done_q) begin
                    done_d      = 1'b0;
                    cnt_d       = '0;
                    rx_valid_d  = 1'b1;
                    rx_data_d   = shift_q;
                    frame_err_d = (stop_q != STOP_LEVEL);
`ifdef UART_RX_PARITY_EN
                    parity_err_d = perr_q;
`endif
                    state_d     = (stop_q == STOP_LEVEL) ? IDLE : BREAK;
                end else if (cnt_q == FULL_M1) begin
                    stop_d = rxs;
                    done_d = 1'b1;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs == IDLE_LEVEL) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx, adapts to UART_RX_PARITY_EN
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int   NB        = 10;
    localparam int   LAT_LIT   = 172;
    localparam int   GAP_LIT   = 176;
    localparam logic PERR_FLIP = 1'b1;
`else
    localparam int   NB        = 9;
    localparam int   LAT_LIT   = 156;
    localparam int   GAP_LIT   = 160;
    localparam logic PERR_FLIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   pulses_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic want_v;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        want_v = 1'b0;
        if (exp_q.size() > 0) want_v = (exp_q[0].cyc == cyc);
        total++;
        if (rx_valid !== want_v) begin
            bad++;
            $display("FAIL rx_valid_timing cyc=%0d got=%b want=%b", cyc, rx_valid, want_v);
        end
        if (rx_valid === 1'b1) pulses_q.push_back(cyc);
        if (want_v) begin
            total++;
            if ({rx_data, parity_err, frame_err} !== {exp_q[0].data, exp_q[0].perr, exp_q[0].ferr}) begin
                bad++;
                $display("FAIL frame_result cyc=%0d got=%h/p%b/f%b want=%h/p%b/f%b", cyc,
                         rx_data, parity_err, frame_err, exp_q[0].data, exp_q[0].perr, exp_q[0].ferr);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        tick(n);
    endtask

    task automatic send_bit(input logic b, input int periods);
        serial_in = b;
        tick(periods * CPB);
    endtask

    // Model: a frame starting at cycle c0 completes 3 + CPB/2 + NB*CPB + 1 cycles later.
    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_bit,
                              input int stop_periods, output int c0);
        exp_t e;
        logic even;
        logic par;
        c0   = cyc;
        even = logic'($countones(d) % 2);
        par  = even ^ flip_par;
        e.cyc  = c0 + 3 + CPB / 2 + NB * CPB + 1;
        e.data = d;
`ifdef UART_RX_PARITY_EN
        e.perr = (par != even);
`else
        e.perr = 1'b0;
`endif
        e.ferr = ~stop_bit;
        exp_q.push_back(e);
        send_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1);
`ifdef UART_RX_PARITY_EN
        send_bit(par, 1);
`endif
        send_bit(stop_bit, stop_periods);
    endtask

    task automatic wait_pulses(input int n, output bit ok);
        int k;
        k = 0;
        while (pulses_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = (pulses_q.size() >= n);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout got=%0d want=%0d", pulses_q.size(), n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        int  c1;
        int  pb;
        int  g0;
        bit  ok;
        bit  seen;

        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_flags", {rx_valid, parity_err, frame_err, busy}, 4'b0000);
        idle(20);

        pb = pulses_q.size();
        send_frame(8'hA5, 1'b0, 1'b1, 1, c0);
        wait_pulses(pb + 1, ok);
        if (ok) chk("latency_a5", pulses_q[pb] - c0, LAT_LIT);
        @(negedge clk);
        chk("data_a5", rx_data, 8'hA5);
        chk("flags_a5", {parity_err, frame_err, busy}, 3'b000);
        idle(20);

        pb = pulses_q.size();
        send_frame(8'h3C, 1'b1, 1'b1, 1, c0);
        wait_pulses(pb + 1, ok);
        @(negedge clk);
        chk("data_3c", rx_data, 8'h3C);
        chk("perr_3c", parity_err, PERR_FLIP);
        chk("ferr_3c", frame_err, 1'b0);
        idle(20);

        pb = pulses_q.size();
        send_frame(8'h7E, 1'b0, 1'b0, 3, c0);
        wait_pulses(pb + 1, ok);
        chk("busy_in_break", busy, 1'b1);
        idle(10);
        chk("busy_after_break", busy, 1'b0);
        chk("data_7e", rx_data, 8'h7E);
        chk("ferr_7e", frame_err, 1'b1);
        chk("count_after_break", pulses_q.size(), pb + 1);
        idle(10);
        send_frame(8'h81, 1'b0, 1'b1, 1, c0);
        wait_pulses(pb + 2, ok);
        @(negedge clk);
        chk("data_81", rx_data, 8'h81);
        chk("ferr_81", frame_err, 1'b0);
        idle(20);

        pb = pulses_q.size();
        g0 = cyc;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        seen = 1'b0;
        while (cyc < g0 + CPB / 2 + 4) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("glitch_busy_seen", seen, 1'b1);
        chk("glitch_busy_done", busy, 1'b0);
        idle(40);
        chk("glitch_no_valid", pulses_q.size(), pb);

        serial_in = 1'b0;
        tick(CPB);
        serial_in = 1'b1;
        tick(3 * CPB);
        chk("busy_mid_data", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_data", rx_data, 8'h00);
        chk("async_rst_flags", {rx_valid, parity_err, frame_err, busy}, 4'b0000);
        exp_q.delete();
        tick(5);
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        pb = pulses_q.size();
        chk("no_partial_byte", rx_data, 8'h00);
        send_frame(8'h12, 1'b0, 1'b1, 1, c0);
        wait_pulses(pb + 1, ok);
        @(negedge clk);
        chk("data_12", rx_data, 8'h12);
        idle(20);

        pb = pulses_q.size();
        send_frame(8'h00, 1'b0, 1'b1, 1, c0);
        send_frame(8'hFF, 1'b0, 1'b1, 1, c1);
        wait_pulses(pb + 2, ok);
        if (ok) chk("b2b_spacing", pulses_q[pb + 1] - pulses_q[pb], GAP_LIT);
        @(negedge clk);
        chk("data_ff", rx_data, 8'hFF);
        chk("flags_ff", {parity_err, frame_err}, 2'b00);
        idle(40);
        chk("pulse_total", pulses_q.size(), pb + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: deserializes frames arriving on a single line into bytes. Each frame is idle-high, one start bit (0), 8 data bits LSB first, an optional even-parity bit, and one stop bit (1). It is the receive end of the transmit path and sits between the external serial pin and the byte-level consumer logic. It presents each byte with a one-cycle valid pulse plus parity and framing error flags.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per bit period. Must be ≥ 4.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- serial_in  input  1  asynchronous serial line; idle level 1.
- rx_data  output  8  last received byte; held until the next frame completes.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch on the last frame; updated with rx_valid, then held.
- frame_err  output  1  stop bit sampled 0 on the last frame; updated with rx_valid, then held.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- serial_in passes through a 2-flop synchronizer (reset value 1). All logic below uses the synchronized signal `rxs`.
- FSM states:
  - IDLE: on a falling edge of rxs (previous 1, current 0), load the bit counter with 0 and go to START.
  - START: when the counter reaches CLKS_PER_BIT/2 − 1 (mid start bit), sample rxs.
    - rxs = 1: false start; return to IDLE with no output.
    - rxs = 0: clear the counter and go to DATA with the bit index at 0.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift rxs into the shift register at position bit index.
    - After bit 7, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: sample at mid-bit. The expected bit is the XOR of the 8 data bits (even parity). Store the mismatch.
  - STOP: sample at mid-bit.
    - On the next cycle: rx_data ← shift register, parity_err ← stored mismatch, frame_err ← ~stop sample, rx_valid = 1.
    - Stop sample 1: go to IDLE.
    - Stop sample 0: go to BREAK.
  - BREAK: wait until rxs = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Back-to-back frames: IDLE is re-entered about half a bit before the nominal frame end. The next start edge is accepted immediately, so there is no required inter-frame gap.
- Reset (async, any state) sets:
  - state = IDLE, counters = 0, shift register = 0
  - rx_data = 8'h00, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0
  - synchronizer flops = 1
- A frame interrupted by reset is discarded; no partial byte is output.

## Timing
- Edge detect: 2 synchronizer cycles plus 1 cycle from the serial_in transition to the START entry.
- Sampling: mid-bit sample points fall at (CLKS_PER_BIT/2) + k·CLKS_PER_BIT cycles after START entry, k = 1..9 (k = 1..10 with parity).
- rx_valid asserts exactly 1 cycle after the stop-bit sample and lasts exactly 1 cycle.
- Total latency, serial_in falling edge to rx_valid: 3 + CLKS_PER_BIT/2 + N·CLKS_PER_BIT + 1 cycles, with N = 9 (no parity) or 10 (parity).
- Tolerated baud mismatch is at least ±3% at CLKS_PER_BIT = 16.
- busy rises 1 cycle after the detected edge. It falls on the cycle rx_valid is pulsed, or on BREAK exit.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the frame includes the even-parity bit; the PARITY state exists; parity_err is live.
  - Undefined: no parity bit; DATA goes directly to STOP; parity_err is tied to 0.
- The setting must match the transmitter build.

## Structure
- Shared package/include `uart_pkg`:
  - state encodings (IDLE, START, DATA, PARITY, STOP, BREAK)
  - DATA_BITS = 8
  - IDLE_LEVEL = 1'b1, START_LEVEL = 1'b0, STOP_LEVEL = 1'b1
  - parity function (XOR reduce)
- One sub-module, `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector. Outputs are `rxs` and `fall`.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and UART_RX_PARITY_EN defined unless noted.
- Byte 0xA5 with parity 0 and stop 1 → rx_data = 0xA5, one rx_valid pulse at the computed latency, parity_err = 0, frame_err = 0.
- Byte 0x3C with parity bit forced to 1 → rx_data = 0x3C, rx_valid pulse, parity_err = 1, frame_err = 0.
- Byte 0x7E with stop bit 0, line held low for 3 bit periods → rx_valid with frame_err = 1; no second frame until the line returns high, then 0x81 is received correctly.
- Line glitch low for 3 cycles, then high → no rx_valid; busy returns to 0 within CLKS_PER_BIT/2 + 4 cycles.
- rst asserted mid-DATA of 0xFF → all outputs 0 immediately (asynchronously); the next frame 0x12 is received correctly with no residue.
- Back-to-back 0x00 then 0xFF with no idle gap, run both with and without the macro → two rx_valid pulses exactly (N + 1)·16 cycles apart with the correct bytes, where N is 9 or 10 as defined under Timing.
